// File: rtl/spi_controller_if.sv
// Host-side byte handshake bundle for spi_controller.
// master: sequencer driving bytes; slave: the controller itself.
interface spi_controller_if;
  logic [7:0] tx_data;
  logic       tx_strobe;
  logic       tx_last;
  logic [7:0] rx_data;
  logic       rx_strobe;
  logic       busy;
  logic       cs_active;

  modport master (
    output tx_data, tx_strobe, tx_last,
    input  rx_data, rx_strobe, busy, cs_active
  );

  modport slave (
    input  tx_data, tx_strobe, tx_last,
    output rx_data, rx_strobe, busy, cs_active
  );
endinterface

// File: rtl/spi_controller.sv
// Byte-oriented SPI mode-0 initiator, MSB first, full duplex, CS held across multi-byte frames.
// Optional SPI_CONTROLLER_LOOPBACK_EN: loopback=1 samples the internal SDO register instead of SDI.
module spi_controller #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  spi_controller_if.slave      host,
  input  logic                 loopback,
  output logic                 spi_sck,
  output logic                 spi_cs,
  output logic                 spi_sdo,
  input  logic                 spi_sdi
);

  localparam logic [7:0] DivLast   = 8'(CLK_DIV - 1);
  localparam logic [7:0] SetupLast = 8'(CS_SETUP - 1);
  localparam logic [7:0] HoldLast  = 8'(CS_HOLD - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StLow,
    StHigh,
    StHold
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_strobe_q, rx_strobe_d;
  logic       last_q, last_d;
  logic       sck_q, sck_d;
  logic       cs_q, cs_d;
  logic       sdo_q, sdo_d;
  logic       sdi_meta_q, sdi_sync_q;
  logic       sample;
  logic [3:0] bit_inc;

`ifdef SPI_CONTROLLER_LOOPBACK_EN
  assign sample = loopback ? sdo_q : sdi_sync_q;
`else
  logic unused_loopback;
  assign unused_loopback = loopback;
  assign sample          = sdi_sync_q;
`endif

  assign bit_inc = bit_cnt_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 8'd1;
    bit_cnt_d   = bit_cnt_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_strobe_d = 1'b0;
    last_d      = last_q;
    cs_d        = cs_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = 8'd0;
        if (host.tx_strobe) begin
          tx_shift_d = host.tx_data;
          last_d     = host.tx_last;
          if (cs_q) begin
            state_d = StSetup;
            cs_d    = 1'b0;
          end else begin
            state_d = StLow;
          end
        end
      end
      StSetup: begin
        if (cnt_q == SetupLast) begin
          state_d = StLow;
          cnt_d   = 8'd0;
        end
      end
      StLow: begin
        if (cnt_q == DivLast) begin
          state_d = StHigh;
          cnt_d   = 8'd0;
        end
      end
      StHigh: begin
        // Last HIGH cycle: sample, then SCK falls on the next edge with the shift.
        if (cnt_q == DivLast) begin
          cnt_d      = 8'd0;
          rx_shift_d = {rx_shift_q[6:0], sample};
          tx_shift_d = {tx_shift_q[6:0], 1'b0};
          if (bit_inc == 4'd8) begin
            bit_cnt_d   = 4'd0;
            rx_data_d   = rx_shift_d;
            rx_strobe_d = 1'b1;
            state_d     = last_q ? StHold : StIdle;
          end else begin
            bit_cnt_d = bit_inc;
            state_d   = StLow;
          end
        end
      end
      StHold: begin
        if (cnt_q == HoldLast) begin
          state_d = StIdle;
          cs_d    = 1'b1;
          cnt_d   = 8'd0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 8'd0;
      end
    endcase

    sck_d = (state_d == StHigh);
    // SDO holds its last bit outside the clocking phases.
    sdo_d = ((state_d == StLow) || (state_d == StHigh)) ? tx_shift_d[7] : sdo_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      bit_cnt_q   <= 4'd0;
      tx_shift_q  <= 8'd0;
      rx_shift_q  <= 8'd0;
      rx_data_q   <= 8'd0;
      rx_strobe_q <= 1'b0;
      last_q      <= 1'b0;
      sck_q       <= 1'b0;
      cs_q        <= 1'b1;
      sdo_q       <= 1'b0;
      sdi_meta_q  <= 1'b0;
      sdi_sync_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_strobe_q <= rx_strobe_d;
      last_q      <= last_d;
      sck_q       <= sck_d;
      cs_q        <= cs_d;
      sdo_q       <= sdo_d;
      sdi_meta_q  <= spi_sdi;
      sdi_sync_q  <= sdi_meta_q;
    end
  end

  assign spi_sck        = sck_q;
  assign spi_cs         = cs_q;
  assign spi_sdo        = sdo_q;
  assign host.rx_data   = rx_data_q;
  assign host.rx_strobe = rx_strobe_q;
  assign host.busy      = (state_q != StIdle);
  assign host.cs_active = ~cs_q;

endmodule

// File: tb/tb_spi_controller.sv
// Self-checking bench for spi_controller: behavioural mode-0 device plus expected-byte scoreboard.
// Honours SPI_CONTROLLER_LOOPBACK_EN to pick loopback expectations.
module tb_spi_controller;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic loopback = 1'b0;
  logic tie0 = 1'b0;
  logic spi_sck, spi_cs, spi_sdo, spi_sdi;

  spi_controller_if bus ();

  spi_controller #(
    .CLK_DIV  (4),
    .CS_SETUP (2),
    .CS_HOLD  (2)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .host     (bus),
    .loopback (loopback),
    .spi_sck  (spi_sck),
    .spi_cs   (spi_cs),
    .spi_sdo  (spi_sdo),
    .spi_sdi  (spi_sdi)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_q [$];
  logic [7:0] sent_q [$];
  logic [7:0] dev_resp_q [$];
  logic [7:0] dev_got_q [$];

  // Mode-0 device: loads a response when CS falls, samples on SCK rise, shifts on SCK fall.
  logic [7:0] dev_tx = 8'h00;
  logic [7:0] dev_rx = 8'h00;
  int         dev_bits = 0;
  logic       prev_cs = 1'b1;
  logic       prev_sck = 1'b0;

  always @(spi_sck or spi_cs) begin
    if (!spi_cs && prev_cs) begin
      dev_tx   = (dev_resp_q.size() > 0) ? dev_resp_q.pop_front() : 8'h00;
      dev_bits = 0;
    end else if (!spi_cs && spi_sck && !prev_sck) begin
      dev_rx   = {dev_rx[6:0], spi_sdo};
      dev_bits = dev_bits + 1;
    end else if (!spi_cs && !spi_sck && prev_sck) begin
      if (dev_bits == 8) begin
        dev_got_q.push_back(dev_rx);
        dev_tx   = (dev_resp_q.size() > 0) ? dev_resp_q.pop_front() : 8'h00;
        dev_bits = 0;
      end else begin
        dev_tx = {dev_tx[6:0], 1'b0};
      end
    end
    prev_cs  = spi_cs;
    prev_sck = spi_sck;
  end

  assign spi_sdi = (tie0 || spi_cs) ? 1'b0 : dev_tx[7];

  int sck_rises = 0;
  int cs_rises = 0;
  int strobes = 0;
  always @(posedge spi_sck) sck_rises++;
  always @(posedge spi_cs) cs_rises++;
  always @(negedge clk) if (bus.rx_strobe) strobes++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Strobe presented for one cycle; returns 1ns into the cycle after acceptance.
  task automatic drive_byte(input logic [7:0] d, input logic last);
    @(posedge clk);
    #1;
    bus.tx_data   = d;
    bus.tx_last   = last;
    bus.tx_strobe = 1'b1;
    @(posedge clk);
    #1;
    bus.tx_strobe = 1'b0;
    bus.tx_data   = 8'h00;
    bus.tx_last   = 1'b0;
  endtask

  task automatic wait_rx(output int k, output bit to);
    k  = 1;
    to = 1'b0;
    @(negedge clk);
    while (!bus.rx_strobe) begin
      if (k >= 400) begin
        to = 1'b1;
        return;
      end
      @(negedge clk);
      k++;
    end
  endtask

  task automatic wait_idle(inout int k, output bit to);
    to = 1'b0;
    while (bus.busy) begin
      if (k >= 800) begin
        to = 1'b1;
        return;
      end
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset;
    int s0;
    bus.tx_data   = 8'h00;
    bus.tx_strobe = 1'b0;
    bus.tx_last   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    s0 = strobes;
    repeat (20) @(negedge clk);
    n_cmp++;
    if ({spi_cs, spi_sck, spi_sdo} !== 3'b100) begin
      n_err++;
      $display("FAIL reset_pins: cs/sck/sdo=%b want 100", {spi_cs, spi_sck, spi_sdo});
    end
    n_cmp++;
    if ({bus.busy, bus.cs_active, bus.rx_strobe} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_status: busy/cs_active/rx_strobe=%b want 000",
               {bus.busy, bus.cs_active, bus.rx_strobe});
    end
    n_cmp++;
    if (bus.rx_data !== 8'h00) begin
      n_err++;
      $display("FAIL reset_rx_data: got %h want 00", bus.rx_data);
    end
    n_cmp++;
    if (strobes != s0) begin
      n_err++;
      $display("FAIL reset_no_strobe: got %0d strobes want 0", strobes - s0);
    end
  endtask

  task automatic test_single_byte;
    int k, r0;
    bit to;
    logic [7:0] e;
    loopback = 1'b1;
`ifdef SPI_CONTROLLER_LOOPBACK_EN
    dev_resp_q.push_back(8'h00);
`else
    dev_resp_q.push_back(8'hA5);
`endif
    exp_q.push_back(8'hA5);
    sent_q.push_back(8'hA5);
    r0 = sck_rises;
    drive_byte(8'hA5, 1'b1);
    n_cmp++;
    if (spi_cs !== 1'b0 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_cs_fall: cs=%b busy=%b want cs=0 busy=1", spi_cs, bus.busy);
    end
    wait_rx(k, to);
    e = exp_q.pop_front();
    n_cmp++;
    if (to || k != 67) begin
      n_err++;
      $display("FAIL single_strobe_time: cycle %0d timeout %0d want 67", k, to);
    end
    n_cmp++;
    if (bus.rx_data !== e) begin
      n_err++;
      $display("FAIL single_rx_data: got %h want %h", bus.rx_data, e);
    end
    wait_idle(k, to);
    n_cmp++;
    if (to || k != 69 || spi_cs !== 1'b1) begin
      n_err++;
      $display("FAIL single_cs_rise: cycle %0d cs=%b want 69 cs=1", k, spi_cs);
    end
    n_cmp++;
    if (sck_rises - r0 != 8) begin
      n_err++;
      $display("FAIL single_sck_edges: got %0d want 8", sck_rises - r0);
    end
    e = sent_q.pop_front();
    n_cmp++;
    if (dev_got_q.size() == 0 || dev_got_q[0] !== e) begin
      n_err++;
      $display("FAIL single_dev_rx: got %h want %h",
               (dev_got_q.size() > 0) ? dev_got_q[0] : 8'hxx, e);
    end
    if (dev_got_q.size() > 0) void'(dev_got_q.pop_front());
    loopback = 1'b0;
  endtask

  task automatic test_back_to_back;
    int k, c0;
    bit to;
    logic [7:0] e;
    dev_resp_q.push_back(8'h3C);
    dev_resp_q.push_back(8'h81);
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'h81);
    sent_q.push_back(8'hC3);
    sent_q.push_back(8'h00);
    drive_byte(8'hC3, 1'b0);
    c0 = cs_rises;
    wait_rx(k, to);
    e = exp_q.pop_front();
    n_cmp++;
    if (to || bus.rx_data !== e) begin
      n_err++;
      $display("FAIL b2b_first_rx: got %h want %h timeout %0d", bus.rx_data, e, to);
    end
    n_cmp++;
    if (spi_cs !== 1'b0 || spi_sck !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_between: cs=%b sck=%b busy=%b want 0 0 0", spi_cs, spi_sck, bus.busy);
    end
    drive_byte(8'h00, 1'b1);
    wait_rx(k, to);
    e = exp_q.pop_front();
    n_cmp++;
    if (to || bus.rx_data !== e) begin
      n_err++;
      $display("FAIL b2b_second_rx: got %h want %h timeout %0d", bus.rx_data, e, to);
    end
    n_cmp++;
    if (cs_rises != c0) begin
      n_err++;
      $display("FAIL b2b_cs_held: cs rose %0d times want 0", cs_rises - c0);
    end
    wait_idle(k, to);
    n_cmp++;
    if (to || spi_cs !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_cs_end: cs=%b timeout %0d want cs=1", spi_cs, to);
    end
    for (int i = 0; i < 2; i++) begin
      e = sent_q.pop_front();
      n_cmp++;
      if (dev_got_q.size() == 0 || dev_got_q[0] !== e) begin
        n_err++;
        $display("FAIL b2b_dev_rx%0d: got %h want %h", i,
                 (dev_got_q.size() > 0) ? dev_got_q[0] : 8'hxx, e);
      end
      if (dev_got_q.size() > 0) void'(dev_got_q.pop_front());
    end
  endtask

  task automatic test_ignore_busy;
    int k, r0, s0;
    bit to;
    logic [7:0] e;
    dev_resp_q.push_back(8'h9E);
    exp_q.push_back(8'h9E);
    sent_q.push_back(8'h12);
    r0 = sck_rises;
    s0 = strobes;
    drive_byte(8'h12, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    bus.tx_data   = 8'hFF;
    bus.tx_last   = 1'b0;
    bus.tx_strobe = 1'b1;
    @(posedge clk);
    #1;
    bus.tx_strobe = 1'b0;
    bus.tx_data   = 8'h00;
    wait_rx(k, to);
    e = exp_q.pop_front();
    n_cmp++;
    if (to || bus.rx_data !== e) begin
      n_err++;
      $display("FAIL ignore_rx: got %h want %h timeout %0d", bus.rx_data, e, to);
    end
    wait_idle(k, to);
    repeat (100) @(negedge clk);
    n_cmp++;
    if (strobes - s0 != 1 || sck_rises - r0 != 8 || bus.busy !== 1'b0 || spi_cs !== 1'b1) begin
      n_err++;
      $display("FAIL ignore_no_extra: strobes %0d sck %0d busy %b cs %b want 1 8 0 1",
               strobes - s0, sck_rises - r0, bus.busy, spi_cs);
    end
    e = sent_q.pop_front();
    n_cmp++;
    if (dev_got_q.size() != 1 || dev_got_q[0] !== e) begin
      n_err++;
      $display("FAIL ignore_dev_rx: %0d bytes, first %h want 1 byte %h", dev_got_q.size(),
               (dev_got_q.size() > 0) ? dev_got_q[0] : 8'hxx, e);
    end
    dev_got_q.delete();
  endtask

  task automatic test_reset_mid;
    int k, s0;
    bit to;
    logic [7:0] e;
    dev_resp_q.push_back(8'hEE);
    drive_byte(8'h77, 1'b1);
    repeat (28) @(posedge clk);
    #1;
    s0 = strobes;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({spi_cs, spi_sck, spi_sdo, bus.busy, bus.cs_active, bus.rx_strobe} !== 6'b100000) begin
      n_err++;
      $display("FAIL midreset_outputs: cs/sck/sdo/busy/csact/rxs=%b want 100000",
               {spi_cs, spi_sck, spi_sdo, bus.busy, bus.cs_active, bus.rx_strobe});
    end
    n_cmp++;
    if (bus.rx_data !== 8'h00) begin
      n_err++;
      $display("FAIL midreset_rx_data: got %h want 00", bus.rx_data);
    end
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (strobes != s0 || dev_got_q.size() != 0) begin
      n_err++;
      $display("FAIL midreset_no_partial: strobes %0d dev bytes %0d want 0 0",
               strobes - s0, dev_got_q.size());
    end
    dev_resp_q.push_back(8'hC6);
    exp_q.push_back(8'hC6);
    sent_q.push_back(8'h5A);
    drive_byte(8'h5A, 1'b1);
    wait_rx(k, to);
    e = exp_q.pop_front();
    n_cmp++;
    if (to || k != 67 || bus.rx_data !== e) begin
      n_err++;
      $display("FAIL midreset_fresh_rx: got %h cycle %0d want %h at 67", bus.rx_data, k, e);
    end
    wait_idle(k, to);
    e = sent_q.pop_front();
    n_cmp++;
    if (to || dev_got_q.size() == 0 || dev_got_q[0] !== e) begin
      n_err++;
      $display("FAIL midreset_dev_rx: got %h want %h",
               (dev_got_q.size() > 0) ? dev_got_q[0] : 8'hxx, e);
    end
    dev_got_q.delete();
  endtask

  task automatic test_loopback_tie0;
    int k;
    bit to;
    logic [7:0] e;
    loopback = 1'b1;
    tie0     = 1'b1;
    dev_resp_q.push_back(8'hAA);
`ifdef SPI_CONTROLLER_LOOPBACK_EN
    exp_q.push_back(8'hFF);
`else
    exp_q.push_back(8'h00);
`endif
    drive_byte(8'hFF, 1'b1);
    wait_rx(k, to);
    e = exp_q.pop_front();
    n_cmp++;
    if (to || bus.rx_data !== e) begin
      n_err++;
      $display("FAIL loopback_tie0_rx: got %h want %h timeout %0d", bus.rx_data, e, to);
    end
    wait_idle(k, to);
    n_cmp++;
    if (to || dev_got_q.size() == 0 || dev_got_q[0] !== 8'hFF) begin
      n_err++;
      $display("FAIL loopback_tie0_pins: dev got %h want ff",
               (dev_got_q.size() > 0) ? dev_got_q[0] : 8'hxx);
    end
    dev_got_q.delete();
    loopback = 1'b0;
    tie0     = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    test_loopback_tie0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
